// File: rtl/alu_muldiv.sv
// Sequential EX-stage ALU: single-cycle logic/arithmetic plus iterative
// shift-add multiply and restoring divide behind a valid/ready handshake.
module alu_muldiv #(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_MULU = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opd;
  logic               neg_lo;
  logic               neg_hi;

  logic [WIDTH-1:0]   sc_lo;
  logic [WIDTH-1:0]   sc_hi;
  logic               sc_dbz;
  logic               sc_ill;
  logic               start_mul;
  logic               start_div;
  logic               op_signed;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_lo_n;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_f;

  logic [WIDTH:0]     div_t;
  logic [WIDTH+1:0]   div_d;
  logic               div_ok;
  logic [WIDTH:0]     div_hi_n;
  logic [WIDTH-1:0]   div_lo_n;
  logic [WIDTH-1:0]   quot_f;
  logic [WIDTH-1:0]   rem_f;

  assign in_ready = (state == IDLE);

  always_comb begin
    sc_lo     = '0;
    sc_hi     = '0;
    sc_dbz    = 1'b0;
    sc_ill    = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    op_signed = 1'b0;
    case (op)
      OP_AND:  sc_lo = a & b;
      OP_OR:   sc_lo = a | b;
      OP_ADD:  sc_lo = a + b;
      OP_XOR:  sc_lo = a ^ b;
      OP_SUB:  sc_lo = a - b;
      OP_SLT:  sc_lo = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: sc_lo = WIDTH'(a < b);
      OP_NOR:  sc_lo = ~(a | b);
      OP_MUL: begin
        start_mul = 1'b1;
        op_signed = 1'b1;
      end
      OP_MULU: start_mul = 1'b1;
      OP_DIV, OP_DIVU: begin
        // Missing divider takes precedence over the divide-by-zero shortcut
        if (!DIV_EN) begin
          sc_ill = 1'b1;
        end else if (b == '0) begin
          sc_lo  = '1;
          sc_hi  = a;
          sc_dbz = 1'b1;
        end else begin
          start_div = 1'b1;
          op_signed = (op == OP_DIV);
        end
      end
      default: sc_ill = 1'b1;
    endcase
  end

  assign a_neg = op_signed & a[WIDTH-1];
  assign b_neg = op_signed & b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  // Shift-add step: multiplier sits in acc_lo and is shifted out as the product shifts in
  assign mul_sum  = acc_hi + (acc_lo[0] ? {1'b0, opd} : '0);
  assign mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
  assign prod     = {mul_sum[WIDTH:1], mul_lo_n};
  assign prod_f   = neg_lo ? -prod : prod;

  // Restoring step: dividend bits shift from acc_lo into the partial remainder
  assign div_t    = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
  assign div_d    = {1'b0, div_t} - {2'b00, opd};
  assign div_ok   = ~div_d[WIDTH+1];
  assign div_hi_n = div_ok ? div_d[WIDTH:0] : div_t;
  assign div_lo_n = {acc_lo[WIDTH-2:0], div_ok};
  assign quot_f   = neg_lo ? -div_lo_n : div_lo_n;
  assign rem_f    = neg_hi ? -div_hi_n[WIDTH-1:0] : div_hi_n[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opd         <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      out_valid   <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            if (start_mul) begin
              state  <= MUL;
              acc_hi <= '0;
              acc_lo <= mag_b;
              opd    <= mag_a;
              cnt    <= CW'(WIDTH - 1);
              neg_lo <= a_neg ^ b_neg;
              neg_hi <= 1'b0;
            end else if (start_div) begin
              state  <= DIV;
              acc_hi <= '0;
              acc_lo <= mag_a;
              opd    <= mag_b;
              cnt    <= CW'(WIDTH - 1);
              neg_lo <= a_neg ^ b_neg;
              neg_hi <= a_neg;
            end else begin
              out_valid   <= 1'b1;
              result_lo   <= sc_lo;
              result_hi   <= sc_hi;
              zero        <= (sc_lo == '0);
              div_by_zero <= sc_dbz;
              illegal_op  <= sc_ill;
            end
          end
        end
        MUL: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc_hi <= {1'b0, mul_sum[WIDTH:1]};
            acc_lo <= mul_lo_n;
            cnt    <= cnt - CW'(1);
            if (cnt == '0) begin
              state       <= IDLE;
              out_valid   <= 1'b1;
              result_lo   <= prod_f[WIDTH-1:0];
              result_hi   <= prod_f[2*WIDTH-1:WIDTH];
              zero        <= (prod_f[WIDTH-1:0] == '0);
              div_by_zero <= 1'b0;
              illegal_op  <= 1'b0;
            end
          end
        end
        DIV: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc_hi <= div_hi_n;
            acc_lo <= div_lo_n;
            cnt    <= cnt - CW'(1);
            if (cnt == '0) begin
              state       <= IDLE;
              out_valid   <= 1'b1;
              result_lo   <= quot_f;
              result_hi   <= rem_f;
              zero        <= (quot_f == '0);
              div_by_zero <= 1'b0;
              illegal_op  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: reset, single-cycle ops, multiply/divide
// latency and boundaries, flush, and back-to-back issue in the result cycle.
module tb_alu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic         in_ready,   nd_in_ready;
  logic         out_valid,  nd_out_valid;
  logic [W-1:0] result_lo,  nd_result_lo;
  logic [W-1:0] result_hi,  nd_result_hi;
  logic         zero,       nd_zero;
  logic         div_by_zero, nd_div_by_zero;
  logic         illegal_op, nd_illegal_op;

  int checks   = 0;
  int failures = 0;
  int lat;
  int busy;
  int seen;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W), .DIV_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .op(op), .a(a), .b(b), .out_valid(out_valid),
    .result_lo(result_lo), .result_hi(result_hi), .zero(zero),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  alu_muldiv #(.WIDTH(W), .DIV_EN(1'b0)) dut_nd (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(nd_in_ready), .op(op), .a(a), .b(b), .out_valid(nd_out_valid),
    .result_lo(nd_result_lo), .result_hi(nd_result_hi), .zero(nd_zero),
    .div_by_zero(nd_div_by_zero), .illegal_op(nd_illegal_op)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers one op for a single cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // lat = edges after the accept edge until out_valid; busy = samples with in_ready low.
  task automatic wait_result();
    lat  = 0;
    busy = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic quiet_window();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_lo",        64'(result_lo), 64'd0);
    chk("rst_zero",      64'(zero),      64'd1);
    chk("rst_flags",     64'({div_by_zero, illegal_op}), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of a multiply
    issue(4'b1001, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midrst_ready", 64'(in_ready),  64'd1);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_zero",  64'(zero),      64'd1);
    @(negedge clk); reset = 1'b1;
    quiet_window();
    chk("midrst_no_result", 64'(seen), 64'd0);

    issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_lo",    64'(result_lo), 64'd0);
    chk("add_zero",  64'(zero),      64'd1);
    chk("add_hi",    64'(result_hi), 64'd0);

    issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
    chk("slt_lo", 64'(result_lo), 64'd1);
    issue(4'b1000, 32'hFFFF_FFFF, 32'd1);
    chk("sltu_lo", 64'(result_lo), 64'd0);

    issue(4'b0100, 32'h55, 32'h66);
    chk("ill_valid", 64'(out_valid),  64'd1);
    chk("ill_flag",  64'(illegal_op), 64'd1);
    chk("ill_lo",    64'(result_lo),  64'd0);
    chk("ill_zero",  64'(zero),       64'd1);

    issue(4'b0110, 32'd5, 32'd7);
    chk("sub_lo",   64'(result_lo),  64'hFFFF_FFFE);
    chk("sub_flag", 64'(illegal_op), 64'd0);
    issue(4'b1100, 32'hF0F0_0000, 32'h0000_0F0F);
    chk("nor_lo", 64'(result_lo), 64'h0F0F_F0F0);
    @(posedge clk); #1;
    chk("pulse_one_cycle", 64'(out_valid), 64'd0);
    chk("hold_lo",         64'(result_lo), 64'h0F0F_F0F0);

    issue(4'b1001, 32'hFFFF_FFFD, 32'h7FFF_FFFF);
    wait_result();
    chk("mul_latency", 64'(lat),  64'd32);
    chk("mul_busy",    64'(busy), 64'd32);
    chk("mul_prod",    {result_hi, result_lo}, 64'hFFFF_FFFE_8000_0003);

    issue(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result();
    chk("mulu_prod", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);

    issue(4'b1011, 32'hFFFF_FFF9, 32'd2);
    wait_result();
    chk("div_latency", 64'(lat), 64'd32);
    chk("div_neg",     {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    issue(4'b1101, 32'd100, 32'd7);
    wait_result();
    chk("divu", {result_hi, result_lo}, {32'd2, 32'd14});

    issue(4'b1011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result();
    chk("div_min",     {result_hi, result_lo}, 64'h0000_0000_8000_0000);
    chk("div_min_dbz", 64'(div_by_zero), 64'd0);

    issue(4'b1011, 32'h1234, 32'd0);
    chk("dbz_valid", 64'(out_valid), 64'd1);
    chk("dbz_res",   {result_hi, result_lo}, 64'h0000_1234_FFFF_FFFF);
    chk("dbz_flag",  64'(div_by_zero), 64'd1);
    chk("nodiv_valid", 64'(nd_out_valid),  64'd1);
    chk("nodiv_ill",   64'(nd_illegal_op), 64'd1);
    chk("nodiv_res",   {nd_result_hi, nd_result_lo}, 64'd0);

    // Flush five cycles into a multiply
    issue(4'b1001, 32'd11, 32'd13);
    repeat (4) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", 64'(in_ready),  64'd1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    quiet_window();
    chk("flush_no_result", 64'(seen), 64'd0);

    // AND offered during the multiply's result cycle
    issue(4'b1010, 32'd3, 32'd5);
    wait_result();
    chk("b2b_mul", 64'(result_lo), 64'd15);
    chk("b2b_ready_in_result", 64'(in_ready), 64'd1);
    op = 4'b0000; a = 32'h0000_F0F0; b = 32'h0000_0FF0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_and_valid", 64'(out_valid), 64'd1);
    chk("b2b_and_lo",    64'(result_lo), 64'h0000_00F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
